// File: rtl/usr_seq.sv
// Command sequencer driving a W-bit universal shift register: clear, shift N, load.
// Define USR_SEQ_ROTATE_EN to let SHR/SHL rotate by feeding usr_q back into the serial-in.
module usr_seq #(
  parameter int W  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [CW-1:0] cmd_cnt,
  input  logic [W-1:0]  cmd_data,
  input  logic          cmd_sin,
  input  logic          cmd_rot,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  rdata,
  output logic [1:0]    usr_s,
  output logic          usr_sisr,
  output logic          usr_sisl,
  output logic [W-1:0]  usr_pin,
  output logic          usr_clear,
  input  logic [W-1:0]  usr_q
);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_RUN  = 3'd2,
    S_CLR  = 3'd3,
    S_CAP  = 3'd4
  } state_t;

  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    usr_s_q, usr_s_d;
  logic          usr_sisr_q, usr_sisr_d;
  logic          usr_sisl_q, usr_sisl_d;
  logic [W-1:0]  usr_pin_q, usr_pin_d;
  logic          usr_clear_q, usr_clear_d;
  logic          done_q, done_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic          fill;

`ifdef USR_SEQ_ROTATE_EN
  logic rot_q, rot_d;
  // A rotating shift leaves the registered serial line at 0; the feedback path supplies the bit.
  assign fill = cmd_sin & ~cmd_rot;
`else
  logic unused_rot;
  assign unused_rot = cmd_rot;
  assign fill       = cmd_sin;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    usr_s_d     = usr_s_q;
    usr_sisr_d  = usr_sisr_q;
    usr_sisl_d  = usr_sisl_q;
    usr_pin_d   = usr_pin_q;
    usr_clear_d = usr_clear_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
`ifdef USR_SEQ_ROTATE_EN
    rot_d       = rot_q;
`endif
    case (state_q)
      S_INIT: begin
        state_d     = S_IDLE;
        usr_clear_d = 1'b0;
      end
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_CLR: begin
              state_d     = S_CLR;
              usr_clear_d = 1'b1;
            end
            OP_LOAD: begin
              state_d   = S_RUN;
              usr_s_d   = OP_LOAD;
              usr_pin_d = cmd_data;
              cnt_d     = CW'(1);
            end
            default: begin
              if (cmd_cnt == '0) begin
                state_d = S_CAP;
                usr_s_d = 2'b00;
              end else begin
                state_d    = S_RUN;
                usr_s_d    = cmd_op;
                cnt_d      = cmd_cnt;
                usr_sisr_d = (cmd_op == OP_SHR) ? fill : 1'b0;
                usr_sisl_d = (cmd_op == OP_SHL) ? fill : 1'b0;
`ifdef USR_SEQ_ROTATE_EN
                rot_d      = cmd_rot;
`endif
              end
            end
          endcase
        end
      end
      S_RUN: begin
        // The operation on the edge leaving cnt==1 is the last one; hold from then on.
        if (cnt_q == CW'(1)) begin
          state_d    = S_CAP;
          usr_s_d    = 2'b00;
          usr_sisr_d = 1'b0;
          usr_sisl_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_CLR: begin
        state_d     = S_CAP;
        usr_clear_d = 1'b0;
      end
      S_CAP: begin
        state_d = S_IDLE;
        rdata_d = usr_q;
        done_d  = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        usr_s_d     = 2'b00;
        usr_sisr_d  = 1'b0;
        usr_sisl_d  = 1'b0;
        usr_clear_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      usr_s_q     <= 2'b00;
      usr_sisr_q  <= 1'b0;
      usr_sisl_q  <= 1'b0;
      usr_pin_q   <= '0;
      usr_clear_q <= 1'b1;
      done_q      <= 1'b0;
      rdata_q     <= '0;
`ifdef USR_SEQ_ROTATE_EN
      rot_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      usr_s_q     <= usr_s_d;
      usr_sisr_q  <= usr_sisr_d;
      usr_sisl_q  <= usr_sisl_d;
      usr_pin_q   <= usr_pin_d;
      usr_clear_q <= usr_clear_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
`ifdef USR_SEQ_ROTATE_EN
      rot_q       <= rot_d;
`endif
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign usr_s     = usr_s_q;
  assign usr_pin   = usr_pin_q;
  assign usr_clear = usr_clear_q;

`ifdef USR_SEQ_ROTATE_EN
  assign usr_sisr = (rot_q && state_q == S_RUN && usr_s_q == OP_SHR) ? usr_q[0]   : usr_sisr_q;
  assign usr_sisl = (rot_q && state_q == S_RUN && usr_s_q == OP_SHL) ? usr_q[W-1] : usr_sisl_q;
`else
  assign usr_sisr = usr_sisr_q;
  assign usr_sisl = usr_sisl_q;
`endif

endmodule

// File: tb/tb_usr_seq.sv
// Directed bench for usr_seq with a behavioural 4-bit universal shift register on its USR port.
module tb_usr_seq;

  logic       clk;
  logic       clear;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_cnt;
  logic [3:0] cmd_data;
  logic       cmd_sin;
  logic       cmd_rot;
  logic       busy;
  logic       done;
  logic [3:0] rdata;
  logic [1:0] usr_s;
  logic       usr_sisr;
  logic       usr_sisl;
  logic [3:0] usr_pin;
  logic       usr_clear;
  logic [3:0] usr_q;

  int checks = 0;
  int errors = 0;

  usr_seq #(.W(4), .CW(3)) dut (
    .clk(clk), .clear(clear),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_cnt(cmd_cnt),
    .cmd_data(cmd_data), .cmd_sin(cmd_sin), .cmd_rot(cmd_rot),
    .busy(busy), .done(done), .rdata(rdata),
    .usr_s(usr_s), .usr_sisr(usr_sisr), .usr_sisl(usr_sisl), .usr_pin(usr_pin),
    .usr_clear(usr_clear), .usr_q(usr_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Universal shift register the sequencer controls.
  always_ff @(posedge clk) begin
    if (usr_clear) usr_q <= 4'b0000;
    else begin
      case (usr_s)
        2'b01:   usr_q <= {usr_sisr, usr_q[3:1]};
        2'b10:   usr_q <= {usr_q[2:0], usr_sisl};
        2'b11:   usr_q <= usr_pin;
        default: usr_q <= usr_q;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one command from an IDLE cycle; lat counts edges from accept to done inclusive.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data,
                         input logic sin, input logic rot, input logic [1:0] mode,
                         output int lat, output int mode_cycles, output logic [3:0] rd);
    cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; cmd_data = data; cmd_sin = sin; cmd_rot = rot;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_cnt = ~cnt; cmd_data = ~data; cmd_sin = ~sin; cmd_rot = ~rot;
    lat = 1;
    mode_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      if (usr_s == mode) mode_cycles++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
    rd = rdata;
    $display("txn op=%b cnt=%0d data=%b sin=%b rot=%b -> lat=%0d mode_cycles=%0d rdata=%b",
             op, cnt, data, sin, rot, lat, mode_cycles, rd);
  endtask

  task automatic test_reset();
    clear = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_cnt = 3'd0;
    cmd_data = 4'h0; cmd_sin = 1'b0; cmd_rot = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (usr_clear !== 1'b1) begin errors++; $display("FAIL rst_usr_clear got %b want 1", usr_clear); end
    checks++; if (usr_s !== 2'b00) begin errors++; $display("FAIL rst_usr_s got %b want 00", usr_s); end
    checks++; if ({usr_sisr, usr_sisl, usr_pin} !== 6'b0) begin errors++; $display("FAIL rst_serial_pin got %b want 000000", {usr_sisr, usr_sisl, usr_pin}); end
    checks++; if ({done, rdata} !== 5'b0) begin errors++; $display("FAIL rst_done_rdata got %b want 00000", {done, rdata}); end
    checks++; if ({cmd_ready, busy} !== 2'b01) begin errors++; $display("FAIL rst_ready_busy got %b want 01", {cmd_ready, busy}); end
    clear = 1'b1;
    #1;
    checks++; if (usr_clear !== 1'b1) begin errors++; $display("FAIL init_usr_clear got %b want 1", usr_clear); end
    @(posedge clk); #1;
    checks++; if (usr_clear !== 1'b0) begin errors++; $display("FAIL idle_usr_clear got %b want 0", usr_clear); end
    checks++; if ({cmd_ready, busy} !== 2'b10) begin errors++; $display("FAIL idle_ready_busy got %b want 10", {cmd_ready, busy}); end
    checks++; if (rdata !== 4'b0000) begin errors++; $display("FAIL idle_rdata got %b want 0000", rdata); end
    checks++; if (usr_q !== 4'b0000) begin errors++; $display("FAIL idle_usr_q got %b want 0000", usr_q); end
  endtask

  task automatic test_load();
    int lat, mc;
    logic [3:0] rd;
    run_cmd(2'b11, 3'd0, 4'b1011, 1'b0, 1'b0, 2'b11, lat, mc, rd);
    checks++; if (lat !== 3) begin errors++; $display("FAIL load_lat got %0d want 3", lat); end
    checks++; if (mc !== 1) begin errors++; $display("FAIL load_mode_cycles got %0d want 1", mc); end
    checks++; if (rd !== 4'b1011) begin errors++; $display("FAIL load_rdata got %b want 1011", rd); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", done); end
  endtask

  task automatic test_shift();
    int lat, mc;
    logic [3:0] rd;
    run_cmd(2'b01, 3'd2, 4'b0000, 1'b1, 1'b0, 2'b01, lat, mc, rd);
    checks++; if (lat !== 4) begin errors++; $display("FAIL shr2_lat got %0d want 4", lat); end
    checks++; if (mc !== 2) begin errors++; $display("FAIL shr2_mode_cycles got %0d want 2", mc); end
    checks++; if (rd !== 4'b1110) begin errors++; $display("FAIL shr2_rdata got %b want 1110", rd); end
    run_cmd(2'b10, 3'd1, 4'b0000, 1'b0, 1'b0, 2'b10, lat, mc, rd);
    checks++; if (lat !== 3) begin errors++; $display("FAIL shl1_lat got %0d want 3", lat); end
    checks++; if (mc !== 1) begin errors++; $display("FAIL shl1_mode_cycles got %0d want 1", mc); end
    checks++; if (rd !== 4'b1100) begin errors++; $display("FAIL shl1_rdata got %b want 1100", rd); end
  endtask

  task automatic test_zero_and_flush();
    int lat, mc;
    logic [3:0] rd;
    run_cmd(2'b10, 3'd0, 4'b0000, 1'b1, 1'b0, 2'b00, lat, mc, rd);
    checks++; if (lat !== 2) begin errors++; $display("FAIL shl0_lat got %0d want 2", lat); end
    checks++; if (mc !== 1) begin errors++; $display("FAIL shl0_hold_cycles got %0d want 1", mc); end
    checks++; if (rd !== 4'b1100) begin errors++; $display("FAIL shl0_rdata got %b want 1100", rd); end
    run_cmd(2'b01, 3'd7, 4'b0000, 1'b0, 1'b0, 2'b01, lat, mc, rd);
    checks++; if (lat !== 9) begin errors++; $display("FAIL shr7_lat got %0d want 9", lat); end
    checks++; if (mc !== 7) begin errors++; $display("FAIL shr7_mode_cycles got %0d want 7", mc); end
    checks++; if (rd !== 4'b0000) begin errors++; $display("FAIL shr7_rdata got %b want 0000", rd); end
    run_cmd(2'b10, 3'd6, 4'b0000, 1'b1, 1'b0, 2'b10, lat, mc, rd);
    checks++; if (lat !== 8) begin errors++; $display("FAIL shl6_lat got %0d want 8", lat); end
    checks++; if (rd !== 4'b1111) begin errors++; $display("FAIL shl6_rdata got %b want 1111", rd); end
  endtask

  task automatic test_back_to_back();
    int lat;
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 4'b0101; cmd_cnt = 3'd0; cmd_sin = 1'b0; cmd_rot = 1'b0;
    @(posedge clk); #1;
    cmd_op = 2'b00;
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    $display("txn b2b load data=0101 -> done=%b rdata=%b", done, rdata);
    checks++; if ({done, rdata} !== 5'b10101) begin errors++; $display("FAIL b2b_load got %b want 10101", {done, rdata}); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done got %b want 1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL b2b_accept got %b want 10", {busy, done}); end
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
    $display("txn b2b clr -> lat=%0d rdata=%b", lat, rdata);
    checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_clr_lat got %0d want 3", lat); end
    checks++; if (rdata !== 4'b0000) begin errors++; $display("FAIL b2b_clr_rdata got %b want 0000", rdata); end
  endtask

  task automatic test_reset_mid();
    int lat, mc, seen;
    logic [3:0] rd;
    run_cmd(2'b11, 3'd0, 4'b1111, 1'b0, 1'b0, 2'b11, lat, mc, rd);
    checks++; if (rd !== 4'b1111) begin errors++; $display("FAIL mid_preload got %b want 1111", rd); end
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_cnt = 3'd5; cmd_sin = 1'b0; cmd_rot = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    #1;
    $display("txn shr5 aborted by clear");
    checks++; if ({usr_clear, usr_s, usr_sisr, usr_sisl} !== 5'b10000) begin errors++; $display("FAIL mid_usr_lines got %b want 10000", {usr_clear, usr_s, usr_sisr, usr_sisl}); end
    checks++; if ({done, rdata} !== 5'b0) begin errors++; $display("FAIL mid_done_rdata got %b want 00000", {done, rdata}); end
    checks++; if ({cmd_ready, busy} !== 2'b01) begin errors++; $display("FAIL mid_ready_busy got %b want 01", {cmd_ready, busy}); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (usr_q !== 4'b0000) begin errors++; $display("FAIL mid_usr_q got %b want 0000", usr_q); end
    clear = 1'b1;
    @(posedge clk); #1;
    checks++; if ({cmd_ready, usr_clear} !== 2'b10) begin errors++; $display("FAIL mid_recover got %b want 10", {cmd_ready, usr_clear}); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_done got %0d want 0", seen); end
  endtask

`ifdef USR_SEQ_ROTATE_EN
  task automatic test_rotate();
    int lat, mc;
    logic [3:0] rd;
    run_cmd(2'b11, 3'd0, 4'b1001, 1'b0, 1'b0, 2'b11, lat, mc, rd);
    checks++; if (rd !== 4'b1001) begin errors++; $display("FAIL rot_preload got %b want 1001", rd); end
    run_cmd(2'b01, 3'd1, 4'b0000, 1'b0, 1'b1, 2'b01, lat, mc, rd);
    checks++; if (rd !== 4'b1100) begin errors++; $display("FAIL rotr1_rdata got %b want 1100", rd); end
    run_cmd(2'b10, 3'd2, 4'b0000, 1'b0, 1'b1, 2'b10, lat, mc, rd);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rotl2_lat got %0d want 4", lat); end
    checks++; if (rd !== 4'b0011) begin errors++; $display("FAIL rotl2_rdata got %b want 0011", rd); end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_shift();
    test_zero_and_flush();
    test_back_to_back();
    test_reset_mid();
`ifdef USR_SEQ_ROTATE_EN
    test_rotate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usr_seq.md
Name: usr_seq

Overview:
- Command sequencer for the 4-bit universal shift register (USR) datapath: owns the USR's mode select, serial-in, parallel-in and sync clear lines and samples its q outputs.
- Accepts one command at a time over a valid/ready handshake: clear, shift right N, shift left N, or parallel load.
- Sequences the USR for the required number of clocks, then returns the final register contents with a one-cycle done pulse.
- Sits between a bus or test controller and the USR instance; the USR clocks on the same clk.

Parameters:
W, 4, USR width; usr_pin/usr_q/cmd_data/rdata width.
CW, 3, shift-count width; counts 0..2^CW-1.

Ports:
clk  input  1  clock, rising edge.
clear  input  1  asynchronous, active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
cmd_op  input  2  00 CLR, 01 SHR, 10 SHL, 11 LOAD.
cmd_cnt  input  CW  shift count for SHR/SHL; ignored otherwise.
cmd_data  input  W  parallel value for LOAD.
cmd_sin  input  1  fill bit shifted in for SHR/SHL.
cmd_rot  input  1  rotate request (only with USR_SEQ_ROTATE_EN).
busy  output  1  command in progress.
done  output  1  one-cycle pulse; rdata valid.
rdata  output  W  USR contents captured at command end.
usr_s  output  2  USR mode: 00 hold, 01 shift right (sisr->q[W-1], q[0] lost), 10 shift left (sisl->q[0]), 11 load.
usr_sisr  output  1  USR right-shift serial in.
usr_sisl  output  1  USR left-shift serial in.
usr_pin  output  W  USR parallel in.
usr_clear  output  1  USR synchronous active-high clear.
usr_q  input  W  USR outputs.

Behaviour:
- All outputs are registered except cmd_ready (= state==IDLE) and busy (= state!=IDLE).
- While clear=0: state INIT, usr_clear=1, usr_s=00, usr_sisr=usr_sisl=0, usr_pin=0, done=0, rdata=0, internal counter=0.
- INIT: one cycle after clear deasserts; usr_clear stays 1 (USR cleared at that edge), then IDLE with usr_clear=0.
- States: INIT, IDLE, RUN, CLR, CAP.
- IDLE, command accepted at edge E0:
  - SHR/SHL with cnt>0: RUN; usr_s=01/10; fill bit = cmd_sin on usr_sisr (SHR) or usr_sisl (SHL), other serial line 0; counter=cnt.
  - LOAD: RUN; usr_s=11; usr_pin=cmd_data; counter=1.
  - CLR: CLR; usr_clear=1.
  - SHR/SHL with cnt=0: CAP directly; usr_s=00; USR untouched.
- RUN: USR performs one operation per edge E1..EN. Counter decrements each edge. When it reaches 1, the next edge moves to CAP with usr_s=00 and serial lines 0. Exactly N operations occur; no extra shift.
- CLR: one cycle; the next edge moves to CAP with usr_clear=0.
- CAP: USR holds. The next edge sets rdata<=usr_q and done<=1, then IDLE.
- done is high for exactly one cycle: the first IDLE cycle. It is cleared on the following edge.
- A command may be accepted in that same cycle (back-to-back).
- Latency from accept edge E0 to done visible:
  - shift N: N+2 edges.
  - LOAD: 3 edges.
  - CLR: 3 edges.
  - cnt=0: 2 edges.
- cmd_* inputs are sampled only at accept; later changes are ignored.
- cmd_valid while busy is ignored; cmd_ready=0.
- Counts greater than W are legal; the register fully flushes to the fill bit.
- Async reset mid-command: immediate return to reset values, command dropped, no done, USR cleared via INIT.
- Illegal states recover to IDLE with usr_s=00.

Optional Feature:
- USR_SEQ_ROTATE_EN defined: on SHR/SHL with cmd_rot=1, the active serial-in is driven combinationally from usr_q each RUN cycle: usr_sisr=usr_q[0] for SHR, usr_sisl=usr_q[W-1] for SHL. The result is a rotate by N; cmd_sin is ignored.
- USR_SEQ_ROTATE_EN undefined: cmd_rot is ignored, and all serial-in lines are registered from cmd_sin as above.

Test Plan:
- Reset release -> usr_clear high for INIT cycle; then cmd_ready=1, busy=0, rdata=0000, usr_q=0000.
- LOAD data=1011 -> usr_s=11 for exactly 1 cycle; done after 3 edges with rdata=1011.
- LOAD 1011, then SHR cnt=2 sin=1 -> usr_s=01 for 2 cycles; rdata=1110. Then SHL cnt=1 sin=0 -> rdata=1100.
- SHL cnt=0 -> done after 2 edges; rdata equals prior contents; usr_s never leaves 00. Next, SHR cnt=7 sin=0 -> rdata=0000.
- Back-to-back: assert cmd_valid continuously with LOAD 0101 then CLR -> second accept occurs in the done cycle; second done gives rdata=0000. Pull clear low mid-SHR -> no done, outputs at reset values.
- With USR_SEQ_ROTATE_EN: LOAD 1001, SHR cnt=1 rot=1 -> rdata=1100; SHL cnt=2 rot=1 -> rdata=0011.
